// File: rtl/serial_pkg.sv
// Shared types and line levels for the serial frame transmitter and its matching receiver.
package serial_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } state_t;

   localparam logic LINE_IDLE   = 1'b1;
   localparam logic START_LEVEL = 1'b0;
   localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Word handshake into the serial frame transmitter: the producer is the master, the transmitter the slave.
interface serial_frame_tx_if #(
   parameter int DATA_W = 8
) ();

   logic [DATA_W-1:0] din;
   logic              din_valid;
   logic              din_ready;

   modport master (output din, output din_valid, input din_ready);
   modport slave  (input din, input din_valid, output din_ready);

endinterface

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each period.
module serial_bit_timer #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic bit_end
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   assign bit_end = (cnt == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear || bit_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start, DATA_W bits LSB first, optional parity, stop.
// Build option: define SERIAL_TX_PARITY_EN to insert an even-parity bit between data and stop.
module serial_frame_tx
   import serial_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   serial_frame_tx_if.slave        in_if,
   output logic                    tx,
   output logic                    busy,
   output logic                    done
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);

   state_t            state_q, state_d;
   logic [DATA_W-1:0] shift_q, shift_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic              tx_d;
   logic              bit_end;
`ifdef SERIAL_TX_PARITY_EN
   logic              parity_q, parity_d;
`endif

   serial_bit_timer #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q == IDLE),
      .bit_end (bit_end)
   );

   assign in_if.din_ready = (state_q == IDLE);
   assign busy            = (state_q != IDLE);

   // NOTE: every signal written here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      done      = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_d  = parity_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (in_if.din_valid) begin
               state_d  = START;
               shift_d  = in_if.din;
`ifdef SERIAL_TX_PARITY_EN
               parity_d = ^in_if.din;
`endif
            end
         end
         START: begin
            if (bit_end) state_d = DATA;
         end
         DATA: begin
            if (bit_end) begin
               shift_d = shift_q >> 1;
               if (bit_cnt_q == LAST_BIT) begin
                  bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
                  state_d   = PARITY;
`else
                  state_d   = STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
               end
            end
         end
`ifdef SERIAL_TX_PARITY_EN
         PARITY: begin
            if (bit_end) state_d = STOP;
         end
`endif
         STOP: begin
            done = bit_end;
            if (bit_end) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // Line level follows the state being entered so tx comes straight off a flop.
      tx_d = LINE_IDLE;
      unique case (state_d)
         START:   tx_d = START_LEVEL;
         DATA:    tx_d = shift_d[0];
`ifdef SERIAL_TX_PARITY_EN
         PARITY:  tx_d = parity_d;
`endif
         STOP:    tx_d = STOP_LEVEL;
         default: tx_d = LINE_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx        <= LINE_IDLE;
`ifdef SERIAL_TX_PARITY_EN
         parity_q  <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx        <= tx_d;
`ifdef SERIAL_TX_PARITY_EN
         parity_q  <= parity_d;
`endif
      end
   end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Scoreboard bench for serial_frame_tx: stimulus queues expected words, a monitor checks each frame.
module tb_serial_frame_tx;

`ifdef SERIAL_TX_PARITY_EN
   localparam int PAR = 1;
   localparam int CPB = 1;
`else
   localparam int PAR = 0;
   localparam int CPB = 4;
`endif
   localparam int NBITS  = 8 + 2 + PAR;
   localparam int F      = NBITS * CPB;
   localparam int BUDGET = 10 * F + 20;

   logic clk;
   logic rst;
   logic tx, busy, done;
   int   cyc;
   int   checks;
   int   failures;
   logic [7:0] exp_q[$];

   serial_frame_tx_if #(.DATA_W(8)) bus ();

   serial_frame_tx #(
      .DATA_W       (8),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .in_if (bus),
      .tx    (tx),
      .busy  (busy),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h at t=%0t", name, got, exp, $time);
      end
   endtask

   // Reference line waveform: one entry per clock, each frame bit held CPB clocks.
   function automatic logic [63:0] model_tx(input logic [7:0] w);
      logic [63:0] v;
      int b;
      v = '0;
      for (int k = 0; k < F; k++) begin
         b = k / CPB;
         if (b == 0)                    v[k] = 1'b0;
         else if (b <= 8)               v[k] = w[b-1];
         else if (PAR == 1 && b == 9)   v[k] = ^w;
         else                           v[k] = 1'b1;
      end
      return v;
   endfunction

   // Monitor: a frame starts when busy is seen high; collect F cycles, then expect one idle cycle.
   initial begin
      logic [7:0]  w;
      logic [63:0] got_tx, got_done;
      logic        bad_ctrl, aborted;
      forever begin
         @(negedge clk);
         if (!rst && busy) begin
            check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
            w = (exp_q.size() != 0) ? exp_q.pop_front() : 8'h00;
            got_tx = '0; got_done = '0; bad_ctrl = 1'b0; aborted = 1'b0;
            for (int k = 0; k < F; k++) begin
               if (k > 0) @(negedge clk);
               if (rst) begin
                  aborted = 1'b1;
                  break;
               end
               got_tx[k]   = tx;
               got_done[k] = done;
               if (!busy || bus.din_ready) bad_ctrl = 1'b1;
            end
            if (!aborted) begin
               check($sformatf("frame_tx_%02h", w), got_tx, model_tx(w));
               check($sformatf("frame_done_%02h", w), got_done, 64'd1 << (F - 1));
               check("frame_ctrl", 64'(bad_ctrl), 64'd0);
               @(negedge clk);
               if (!rst)
                  check("idle_after_frame", {60'd0, tx, busy, bus.din_ready, done}, 64'b1010);
            end
         end
      end
   end

   task automatic send(input logic [7:0] w, input bit keep, output int acc);
      int n;
      n = 0;
      @(negedge clk);
      bus.din       = w;
      bus.din_valid = 1'b1;
      while (!bus.din_ready && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      check("accept_in_budget", 64'(n < BUDGET), 64'd1);
      acc = -1;
      if (n < BUDGET) begin
         exp_q.push_back(w);
         @(posedge clk);
         #1;
         acc = cyc;
      end
      if (!keep || n >= BUDGET) begin
         bus.din_valid = 1'b0;
         bus.din       = 8'($urandom);
      end
   endtask

   initial begin
      int a1, a2, n;
      logic bad;
      checks = 0; failures = 0;
      rst = 1'b1;
      bus.din = 8'h00;
      bus.din_valid = 1'b0;
      #1;
      check("reset_outputs", {60'd0, tx, busy, bus.din_ready, done}, 64'b1010);
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      repeat (2) @(posedge clk);

      // Single frame, with a second word held on the bus while busy; it must wait for idle.
      send(8'hA5, 1'b1, a1);
      bus.din = 8'h3C;
      bus.din_valid = 1'b1;
      send(8'h3C, 1'b0, a2);
      check("holdoff_accept_gap", 64'(a2 - a1), 64'(F + 1));

      // Back-to-back all-zero then all-one data.
      send(8'h00, 1'b1, a1);
      send(8'hFF, 1'b0, a2);
      check("b2b_accept_gap", 64'(a2 - a1), 64'(F + 1));

      send(8'h07, 1'b0, a1);

      // Abort during data bit 3 (frame bit index 4).
      send(8'hC3, 1'b0, a1);
      repeat (4 * CPB) @(posedge clk);
      #2;
      check("pre_abort_tx", 64'(tx), 64'd0);
      rst = 1'b1;
      #1;
      check("abort_outputs", {60'd0, tx, busy, bus.din_ready, done}, 64'b1010);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
      bad = 1'b0;
      for (int k = 0; k < 2 * F; k++) begin
         @(negedge clk);
         if (busy || !tx || done) bad = 1'b1;
      end
      check("no_resume_after_abort", 64'(bad), 64'd0);
      send(8'h81, 1'b0, a1);

      // Randomized words, gaps and held-valid runs.
      for (int i = 0; i < 20; i++) begin
         send(8'($urandom), ($urandom_range(0, 2) == 0), a1);
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      bus.din_valid = 1'b0;

      n = 0;
      while ((exp_q.size() != 0 || busy) && n < BUDGET) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Parallel-to-serial frame transmitter that drives a single-wire serial line.
- Accepts one DATA_W-bit word per valid/ready handshake, then emits the frame LSB first: start bit, data bits, optional parity bit, stop bit.
- Each bit is held for CLKS_PER_BIT clocks.
- Sits at the driving end of the team's serial capture path; its line output feeds flip-flop-based receivers.

Parameters:
- DATA_W, 8, number of data bits per frame (>= 1).
- CLKS_PER_BIT, 4, clock cycles each serial bit is held (>= 1).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  DATA_W  word to transmit; sampled on handshake.
- din_valid  input  1  word available on din.
- din_ready  output  1  block can accept a word.
- tx  output  1  serial line, registered; idle level 1.
- busy  output  1  frame in progress.
- done  output  1  one-cycle pulse in the final stop-bit cycle.

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-high, rst.
- Reset values (applied immediately on rst assertion, independent of clk):
  - tx=1, busy=0, din_ready=1, done=0.
  - State IDLE; bit counter and cycle counter = 0; shift register = 0.
- States: IDLE, START, DATA, PARITY (only with the macro), STOP.
- Handshake:
  - Transfer occurs on a rising edge where din_valid && din_ready.
  - din is latched into the shift register on that edge.
  - din_valid is ignored while din_ready=0; din may change freely then.
- After the accepting edge:
  - State=START, tx=0, busy=1, din_ready=0.
  - Each bit state lasts exactly CLKS_PER_BIT cycles, timed by a cycle counter that runs 0..CLKS_PER_BIT-1.
- Sequencing:
  - START -> DATA when the cycle counter reaches CLKS_PER_BIT-1.
  - DATA: tx = shift register bit 0. The register shifts right at the end of each bit period. Bit counter runs 0..DATA_W-1.
  - Leaving DATA after bit DATA_W-1 goes to PARITY (macro defined) or STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. done=1 during the last STOP cycle only.
  - STOP then returns to IDLE: busy=0, din_ready=1.
- Frame length is (DATA_W+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT when parity is enabled.
- Back-to-back frames:
  - The earliest next accept is the first IDLE cycle.
  - The line therefore idles high for the stop bit plus at least one clock between frames.
- CLKS_PER_BIT=1: every state lasts exactly one cycle; the counter stays at 0.
- Counter widths:
  - Cycle counter: $clog2(CLKS_PER_BIT), minimum 1 bit.
  - Bit counter: $clog2(DATA_W), minimum 1 bit.
  - Compare against the parameter minus 1; no wrap beyond terminal count.
- Reset mid-frame: the frame is aborted, tx returns to 1 immediately, and nothing resumes after rst deasserts.
- tx is glitch-free because it is driven only from a flop.

Optional Feature:
- Macro: SERIAL_TX_PARITY_EN.
- Defined:
  - PARITY state inserted between DATA and STOP for CLKS_PER_BIT cycles.
  - tx = even parity (XOR reduction) of the latched word, captured at accept.
  - Frame is (DATA_W+3)*CLKS_PER_BIT cycles.
- Undefined: the PARITY state and parity register are absent from the RTL; DATA goes directly to STOP.

Decomposition:
- Package serial_pkg:
  - Typedef for the state enum (IDLE, START, DATA, PARITY, STOP).
  - Constants LINE_IDLE=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- Sub-module serial_bit_timer:
  - Parameterized by CLKS_PER_BIT; inputs clk, rst, clear.
  - Outputs bit_end, high on the last cycle of each bit period.
  - Reused later by the matching receiver.

Test Plan:
1. Reset: assert rst mid-cycle -> tx=1, busy=0, din_ready=1, done=0 immediately, before the next clk edge.
2. Single frame, DATA_W=8, CLKS_PER_BIT=4, din=8'hA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles. done pulses once in cycle 40 after accept. din_ready returns high the next cycle.
3. Hold-off: keep din_valid=1 with din=8'h3C while busy -> no second latch. The frame still carries 8'hA5; 8'h3C is accepted only in the first IDLE cycle.
4. Back-to-back: 8'h00 then 8'hFF -> line is high for 4 stop cycles plus 1 idle cycle between frames. Data bits are all 0, then all 1.
5. Abort: assert rst during data bit 3 -> tx=1 at once and the frame is dropped. After release, a new word 8'h81 transmits correctly.
6. With SERIAL_TX_PARITY_EN and CLKS_PER_BIT=1, din=8'h07 -> sequence 0,1,1,1,0,0,0,0,0,1(parity),1(stop). done is asserted in cycle 11.
